parity_frame_checker: RTL and testbench

Serial receive-side parity checker that consumes the one-bit XOR stream produced by the upstream gate/serializer stage. It shifts in `DATA_BITS` data bits LSB-first, followed by one parity bit. It keeps a running XOR of every accepted bit, then presents the assembled word, a parity-error flag and a one-cycle completion pulse. A saturating error counter gives link-quality statistics to downstream logic.

---
 rtl/parity_frame_checker.sv | 113 +++++++++++
 tb/tb_parity_frame_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Receive-side serial parity checker: assembles DATA_BITS data bits (LSB first)
// plus one parity bit, flags parity errors and keeps a saturating error count.
module parity_frame_checker #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 abort,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic [7:0]           err_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [CNT_W-1:0]       cnt;
  logic                   parity;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   last_data;
  logic                   frame_err;

  assign last_data = (cnt == CNT_W'(DATA_BITS - 1));
  assign frame_err = ((parity ^ bit_in) != ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else if (bit_valid) begin
      case (state)
        IDLE:    next_state = (DATA_BITS == 1) ? PAR : DATA;
        DATA:    next_state = last_data ? PAR : DATA;
        PAR:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Bits are OR-ed into place by position; the register is cleared whenever a
  // frame starts or is aborted, so positions above cnt are always zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      parity     <= 1'b0;
      shift_reg  <= '0;
      data_out   <= '0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        cnt       <= '0;
        parity    <= 1'b0;
        shift_reg <= '0;
      end else if (bit_valid) begin
        case (state)
          IDLE: begin
            shift_reg <= DATA_BITS'(bit_in);
            parity    <= bit_in;
            cnt       <= CNT_W'(1);
          end
          DATA: begin
            shift_reg <= shift_reg | (DATA_BITS'(bit_in) << cnt);
            parity    <= parity ^ bit_in;
            cnt       <= cnt + CNT_W'(1);
          end
          PAR: begin
            data_out   <= shift_reg;
            parity_err <= frame_err;
            frame_done <= 1'b1;
            if (frame_err && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
            cnt    <= '0;
            parity <= 1'b0;
          end
          default: begin
            cnt    <= '0;
            parity <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized and directed bench for parity_frame_checker; an even- and an
// odd-parity instance see the same bit stream and are compared to a frame model.
module tb_parity_frame_checker;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          abort;

  logic [DB-1:0] data_e, data_o;
  logic          done_e, done_o;
  logic          err_e, err_o;
  logic [7:0]    cnt_e, cnt_o;
  logic          busy_e, busy_o;

  int checks   = 0;
  int failures = 0;

  // Frame-level model: bits collected so far, their XOR, and published results.
  int            nbits;
  logic [DB-1:0] acc;
  bit            par;
  logic [DB-1:0] m_data;
  bit            m_done;
  bit            m_err_even, m_err_odd;
  int            m_cnt_even, m_cnt_odd;

  parity_frame_checker #(.DATA_BITS(DB), .ODD(1'b0)) u_even (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .abort      (abort),
    .data_out   (data_e),
    .frame_done (done_e),
    .parity_err (err_e),
    .err_count  (cnt_e),
    .busy       (busy_e)
  );

  parity_frame_checker #(.DATA_BITS(DB), .ODD(1'b1)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .abort      (abort),
    .data_out   (data_o),
    .frame_done (done_o),
    .parity_err (err_o),
    .err_count  (cnt_o),
    .busy       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    nbits      = 0;
    acc        = '0;
    par        = 1'b0;
    m_data     = '0;
    m_done     = 1'b0;
    m_err_even = 1'b0;
    m_err_odd  = 1'b0;
    m_cnt_even = 0;
    m_cnt_odd  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " even.data_out"},   32'(data_e), 32'(m_data));
    check({tag, " even.frame_done"}, 32'(done_e), 32'(m_done));
    check({tag, " even.parity_err"}, 32'(err_e),  32'(m_err_even));
    check({tag, " even.err_count"},  32'(cnt_e),  32'(m_cnt_even));
    check({tag, " even.busy"},       32'(busy_e), 32'(nbits != 0));
    check({tag, " odd.data_out"},    32'(data_o), 32'(m_data));
    check({tag, " odd.frame_done"},  32'(done_o), 32'(m_done));
    check({tag, " odd.parity_err"},  32'(err_o),  32'(m_err_odd));
    check({tag, " odd.err_count"},   32'(cnt_o),  32'(m_cnt_odd));
    check({tag, " odd.busy"},        32'(busy_o), 32'(nbits != 0));
  endtask

  // One clock: drive inputs, advance the model at the edge, sample 1 ns later.
  task automatic step(input string tag, input logic b, input logic v, input logic ab);
    bit total;
    bit_in    = b;
    bit_valid = v;
    abort     = ab;
    @(posedge clk);
    m_done = 1'b0;
    if (ab) begin
      nbits = 0;
      acc   = '0;
      par   = 1'b0;
    end else if (v) begin
      if (nbits < DB) begin
        acc[nbits] = b;
        par        = par ^ b;
        nbits++;
      end else begin
        total      = par ^ b;
        m_data     = acc;
        m_err_even = (total != 1'b0);
        m_err_odd  = (total != 1'b1);
        if (m_err_even && m_cnt_even < 255) m_cnt_even++;
        if (m_err_odd && m_cnt_odd < 255) m_cnt_odd++;
        m_done = 1'b1;
        nbits  = 0;
        acc    = '0;
        par    = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic send_frame(input string tag, input logic [DB-1:0] d, input logic p, input int gap);
    for (int i = 0; i < DB; i++) begin
      step(tag, d[i], 1'b1, 1'b0);
      repeat (gap) step(tag, 1'bx, 1'b0, 1'b0);
    end
    step(tag, p, 1'b1, 1'b0);
  endtask

  initial begin
    logic [DB-1:0] d;
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    abort     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    step("idle", 1'bx, 1'b0, 1'b0);

    send_frame("a5", 8'hA5, 1'b0, 0);
    check("a5 data", 32'(data_e), 32'h0000_00A5);
    check("a5 err", 32'(err_e), 32'd0);
    step("a5 tail", 1'b0, 1'b0, 1'b0);

    send_frame("bad07", 8'h07, 1'b0, 0);
    check("bad07 err", 32'(err_e), 32'd1);
    check("bad07 count", 32'(cnt_e), 32'd1);
    send_frame("good07", 8'h07, 1'b1, 0);
    check("good07 err", 32'(err_e), 32'd0);
    check("good07 count", 32'(cnt_e), 32'd1);

    send_frame("gap3c", 8'h3C, 1'b0, 2);
    check("gap3c data", 32'(data_e), 32'h0000_003C);
    step("gap3c tail", 1'b0, 1'b0, 1'b0);

    step("abort", 1'b1, 1'b1, 1'b0);
    step("abort", 1'b0, 1'b1, 1'b0);
    step("abort", 1'b1, 1'b1, 1'b0);
    step("abort", 1'b1, 1'b1, 1'b1);
    send_frame("ff", 8'hFF, 1'b0, 0);
    check("ff data", 32'(data_e), 32'h0000_00FF);
    check("ff err", 32'(err_e), 32'd0);

    send_frame("b2b01", 8'h01, 1'b1, 0);
    check("b2b01 data", 32'(data_e), 32'h0000_0001);
    send_frame("b2b80", 8'h80, 1'b1, 0);
    check("b2b80 data", 32'(data_e), 32'h0000_0080);
    for (int i = 0; i < 4; i++) step("prerst", 1'(i % 2), 1'b1, 1'b0);
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async rst");
    @(posedge clk);
    #1;
    check_outputs("held rst");
    rst = 1'b0;
    send_frame("postrst", 8'h5A, 1'b0, 0);
    check("postrst data", 32'(data_e), 32'h0000_005A);

    for (int i = 0; i < 1500; i++) begin
      step("random", 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
    end

    if (nbits != 0) step("flush", 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 300; f++) begin
      d = DB'($urandom);
      send_frame("sat", d, ~(^d), int'($urandom_range(0, 1)));
    end
    check("sat even count", 32'(cnt_e), 32'd255);
    send_frame("odd00", 8'h00, 1'b1, 0);
    check("odd00 odd err", 32'(err_o), 32'd0);
    check("odd00 even err", 32'(err_e), 32'd1);
    check("odd00 even count", 32'(cnt_e), 32'd255);
    step("end", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
